// File: rtl/timer_sched_pkg.sv
// ---------------------------------------------------------------------------
// timer_sched_pkg
// Shared constants and types for the multi-channel timer scheduler:
//   - word addresses of the memory-mapped register file
//   - bit positions inside CTRL and CHCTRL
//   - a per-channel state record used to build the read-back view
// ---------------------------------------------------------------------------
package timer_sched_pkg;

   // Register map (word addresses on s_address)
   localparam logic [3:0] ADDR_CTRL        = 4'd0;
   localparam logic [3:0] ADDR_PRESCALE    = 4'd1;
   localparam logic [3:0] ADDR_STATUS      = 4'd2;
   localparam logic [3:0] ADDR_IRQ_EN      = 4'd3;
   localparam logic [3:0] ADDR_PERIOD_BASE = 4'd4;
   localparam logic [3:0] ADDR_CHCTRL_BASE = 4'd8;
   localparam logic [3:0] ADDR_COUNT_BASE  = 4'd12;

   // Bit positions
   localparam int GEN_BIT      = 0;
   localparam int RUN_BIT      = 0;
   localparam int PERIODIC_BIT = 1;

   // Width of the register file data path
   localparam int REG_W = 32;

   // Per-channel state as seen from the bus (zero-extended to REG_W)
   typedef struct packed {
      logic [REG_W-1:0] period;
      logic [REG_W-1:0] count;
      logic             run;
      logic             periodic;
   } chan_state_t;

endpackage

// File: rtl/timer_sched_chan.sv
// ---------------------------------------------------------------------------
// timer_sched_chan
// One countdown channel of the timer scheduler.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : shared prescaler tick (one-cycle pulse)
//   load         : start request, loads count from period and sets run
//   stop         : stop request, clears run and freezes count
//   period       : reload value
//   periodic     : reload on expiry instead of stopping
//   count        : current count
//   run          : channel running
//   expire       : combinational pulse, high in the cycle an expiry occurs
// ---------------------------------------------------------------------------
module timer_sched_chan
   import timer_sched_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             load,
   input  logic             stop,
   input  logic [CNT_W-1:0] period,
   input  logic             periodic,
   output logic [CNT_W-1:0] count,
   output logic             run,
   output logic             expire
);

   // A start or stop request in the same cycle as a tick takes priority,
   // so the tick is simply lost for this channel.
   assign expire = tick && run && (count == '0) && !load && !stop;

   // Countdown state: load beats stop beats tick. At zero the channel either
   // reloads (periodic) or stops with count parked at zero; it never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         run   <= 1'b0;
      end else if (load) begin
         count <= period;
         run   <= 1'b1;
      end else if (stop) begin
         run   <= 1'b0;
      end else if (tick && run) begin
         if (count != '0) begin
            count <= count - CNT_W'(1);
         end else if (periodic) begin
            count <= period;
         end else begin
            run   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// ---------------------------------------------------------------------------
// timer_sched
// Multi-channel timer scheduler with an Avalon-style slave interface.
// A shared prescaler produces ticks that drive NCH countdown channels; each
// expiry sets a pending flag, and masked pending flags form a registered irq.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   s_cs_n         : chip select, active low
//   s_address      : word address
//   s_read/s_write : strobes, qualified by ~s_cs_n
//   s_writedata    : write data
//   s_readdata     : registered read data, valid the cycle after s_read
//   irq            : registered |(pending & IRQ_EN)
// ---------------------------------------------------------------------------
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 32,
   parameter int PRE_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_cs_n,
   input  logic [3:0]        s_address,
   input  logic              s_read,
   output logic [REG_W-1:0]  s_readdata,
   input  logic              s_write,
   input  logic [REG_W-1:0]  s_writedata,
   output logic              irq
);

   logic             bus_wr;
   logic             bus_rd;
   logic             gen;
   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [NCH-1:0]   pending;
   logic [NCH-1:0]   irq_en;
   logic [NCH-1:0]   periodic;
   logic [NCH-1:0]   run;
   logic [NCH-1:0]   expire;
   logic [NCH-1:0]   load;
   logic [NCH-1:0]   stop;
   logic [CNT_W-1:0] period [NCH];
   logic [CNT_W-1:0] count  [NCH];
   chan_state_t      chan_view [4];
   logic [REG_W-1:0] rd_val;

   assign bus_wr = ~s_cs_n & s_write;
   assign bus_rd = ~s_cs_n & s_read;

   // Global control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gen      <= 1'b0;
         prescale <= '0;
         irq_en   <= '0;
      end else if (bus_wr) begin
         if (s_address == ADDR_CTRL)     gen      <= s_writedata[GEN_BIT];
         if (s_address == ADDR_PRESCALE) prescale <= s_writedata[PRE_W-1:0];
         if (s_address == ADDR_IRQ_EN)   irq_en   <= s_writedata[NCH-1:0];
      end
   end

   // Prescaler: the tick is the cycle in which the counter sits at PRESCALE.
   // Rewriting PRESCALE restarts the interval from zero.
   assign tick = gen && (pre_cnt == prescale);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (!gen || tick || (bus_wr && s_address == ADDR_PRESCALE)) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Pending flags: expiry set has priority over write-1-to-clear.
   // irq trails pending/mask by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         if (bus_wr && s_address == ADDR_STATUS) begin
            pending <= (pending & ~s_writedata[NCH-1:0]) | expire;
         end else begin
            pending <= pending | expire;
         end
         irq <= |(pending & irq_en);
      end
   end

   // Per-channel PERIOD/CHCTRL registers and countdown instance
   for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
      logic             sel_chctrl;
      logic [CNT_W-1:0] period_q;
      logic             periodic_q;

      assign sel_chctrl = bus_wr && (s_address == ADDR_CHCTRL_BASE + 4'(ch));
      assign load[ch]   = sel_chctrl &&  s_writedata[RUN_BIT];
      assign stop[ch]   = sel_chctrl && !s_writedata[RUN_BIT];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            period_q   <= '0;
            periodic_q <= 1'b0;
         end else begin
            if (bus_wr && s_address == ADDR_PERIOD_BASE + 4'(ch)) period_q <= s_writedata[CNT_W-1:0];
            if (sel_chctrl) periodic_q <= s_writedata[PERIODIC_BIT];
         end
      end

      assign period[ch]   = period_q;
      assign periodic[ch] = periodic_q;

      timer_sched_chan #(.CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .tick     (tick),
         .load     (load[ch]),
         .stop     (stop[ch]),
         .period   (period[ch]),
         .periodic (periodic[ch]),
         .count    (count[ch]),
         .run      (run[ch]),
         .expire   (expire[ch])
      );
   end

   // The map always has four channel slots; slots beyond NCH read as zero.
   for (genvar gv = 0; gv < 4; gv++) begin : g_view
      if (gv < NCH) begin : g_used
         assign chan_view[gv] = '{period:   REG_W'(period[gv]),
                                  count:    REG_W'(count[gv]),
                                  run:      run[gv],
                                  periodic: periodic[gv]};
      end else begin : g_unused
         assign chan_view[gv] = '0;
      end
   end

   // Read mux
   always_comb begin
      rd_val = '0;
      case (s_address)
         ADDR_CTRL:     rd_val[GEN_BIT]     = gen;
         ADDR_PRESCALE: rd_val[PRE_W-1:0]   = prescale;
         ADDR_STATUS:   rd_val[NCH-1:0]     = pending;
         ADDR_IRQ_EN:   rd_val[NCH-1:0]     = irq_en;
         default: begin
            if (s_address[3:2] == ADDR_PERIOD_BASE[3:2]) begin
               rd_val = chan_view[s_address[1:0]].period;
            end else if (s_address[3:2] == ADDR_CHCTRL_BASE[3:2]) begin
               rd_val[RUN_BIT]      = chan_view[s_address[1:0]].run;
               rd_val[PERIODIC_BIT] = chan_view[s_address[1:0]].periodic;
            end else begin
               rd_val = chan_view[s_address[1:0]].count;
            end
         end
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_readdata <= '0;
      end else if (bus_rd) begin
         s_readdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_timer_sched.sv
// ---------------------------------------------------------------------------
// tb_timer_sched
// Self-checking bench for timer_sched. Bus reads push their expected data to
// a scoreboard queue; a monitor pops and compares when the read data appears.
// ---------------------------------------------------------------------------
module tb_timer_sched;
   import timer_sched_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        s_cs_n;
   logic [3:0]  s_address;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   string       tagQ[$];
   logic [31:0] expQ[$];
   logic        readSeen;

   timer_sched #(.NCH(4), .CNT_W(32), .PRE_W(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_cs_n      (s_cs_n),
      .s_address   (s_address),
      .s_read      (s_read),
      .s_readdata  (s_readdata),
      .s_write     (s_write),
      .s_writedata (s_writedata),
      .irq         (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One bus cycle, entered and left on a falling edge
   task automatic applyStimulus(input logic isWrite, input logic [3:0] addr, input logic [31:0] data);
      s_cs_n      = 1'b0;
      s_write     = isWrite;
      s_read      = !isWrite;
      s_address   = addr;
      s_writedata = data;
      @(negedge clk);
      s_cs_n      = 1'b1;
      s_write     = 1'b0;
      s_read      = 1'b0;
   endtask

   task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
      applyStimulus(1'b1, addr, data);
   endtask

   task automatic busRead(input string tag, input logic [3:0] addr, input logic [31:0] expected);
      tagQ.push_back(tag);
      expQ.push_back(expected);
      applyStimulus(1'b0, addr, 32'd0);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: a read strobe seen at a rising edge is checked at
   // the following falling edge
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) readSeen <= 1'b0;
      else          readSeen <= !s_cs_n && s_read;
   end

   always @(negedge clk) begin
      if (readSeen && expQ.size() != 0) begin
         checkOutput(tagQ.pop_front(), s_readdata, expQ.pop_front());
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      s_cs_n      = 1'b1;
      s_read      = 1'b0;
      s_write     = 1'b0;
      s_address   = 4'd0;
      s_writedata = 32'd0;
      idleCycles(3);
      checkOutput("rst_readdata", s_readdata, 32'd0);
      checkOutput("rst_irq", 32'(irq), 32'd0);
      reset_n = 1'b1;
      idleCycles(1);

      // Reset while a channel is running
      busWrite(ADDR_PRESCALE, 32'd0);
      busWrite(ADDR_PERIOD_BASE, 32'd5);
      busWrite(ADDR_IRQ_EN, 32'd1);
      busWrite(ADDR_CHCTRL_BASE, 32'h3);
      busWrite(ADDR_CTRL, 32'd1);
      idleCycles(20);
      checkOutput("run_irq_before_reset", 32'(irq), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midrun_reset_irq", 32'(irq), 32'd0);
      checkOutput("midrun_reset_readdata", s_readdata, 32'd0);
      idleCycles(2);
      reset_n = 1'b1;
      idleCycles(1);
      for (int a = 0; a < 16; a++) begin
         busRead($sformatf("rst_reg%0d", a), 4'(a), 32'd0);
      end
      idleCycles(20);
      checkOutput("post_reset_irq", 32'(irq), 32'd0);
      busRead("post_reset_status", ADDR_STATUS, 32'd0);
      busRead("post_reset_count0", ADDR_COUNT_BASE, 32'd0);

      // One-shot: PRESCALE=3, PERIOD=2 -> expiry 12 clocks after GEN write
      busWrite(ADDR_PRESCALE, 32'd3);
      busWrite(ADDR_PERIOD_BASE, 32'd2);
      busWrite(ADDR_IRQ_EN, 32'd1);
      busWrite(ADDR_CHCTRL_BASE, 32'h1);
      busWrite(ADDR_CTRL, 32'd1);
      idleCycles(11);
      busRead("oneshot_status_early", ADDR_STATUS, 32'd0);
      checkOutput("oneshot_irq_early", 32'(irq), 32'd0);
      busRead("oneshot_status_set", ADDR_STATUS, 32'd1);
      checkOutput("oneshot_irq_set", 32'(irq), 32'd1);
      busRead("oneshot_count", ADDR_COUNT_BASE, 32'd0);
      busRead("oneshot_chctrl", ADDR_CHCTRL_BASE, 32'd0);
      idleCycles(10);
      busRead("oneshot_count_nowrap", ADDR_COUNT_BASE, 32'd0);
      busWrite(ADDR_CTRL, 32'd0);
      busWrite(ADDR_STATUS, 32'd1);
      busWrite(ADDR_IRQ_EN, 32'd0);

      // Periodic with write-1-to-clear: expiry every 5 clocks
      busWrite(ADDR_PRESCALE, 32'd0);
      busWrite(ADDR_PERIOD_BASE + 4'd1, 32'd4);
      busWrite(ADDR_IRQ_EN, 32'd2);
      busWrite(ADDR_CHCTRL_BASE + 4'd1, 32'h3);
      busWrite(ADDR_CTRL, 32'd1);
      idleCycles(5);
      checkOutput("periodic_irq_pre", 32'(irq), 32'd0);
      idleCycles(1);
      checkOutput("periodic_irq_first", 32'(irq), 32'd1);
      busWrite(ADDR_STATUS, 32'h2);
      checkOutput("periodic_irq_hold", 32'(irq), 32'd1);
      idleCycles(1);
      checkOutput("periodic_irq_cleared", 32'(irq), 32'd0);
      busRead("periodic_status_cleared", ADDR_STATUS, 32'd0);
      idleCycles(1);
      checkOutput("periodic_irq_gap", 32'(irq), 32'd0);
      idleCycles(1);
      checkOutput("periodic_irq_second", 32'(irq), 32'd1);
      busRead("periodic_status_second", ADDR_STATUS, 32'h2);
      busWrite(ADDR_CHCTRL_BASE + 4'd1, 32'h0);
      busWrite(ADDR_STATUS, 32'hF);

      // Clear of pending[2] in the expiry cycle: set wins
      busWrite(ADDR_PERIOD_BASE + 4'd2, 32'd3);
      busWrite(ADDR_CHCTRL_BASE + 4'd2, 32'h3);
      idleCycles(3);
      busWrite(ADDR_STATUS, 32'h4);
      busRead("collision_status", ADDR_STATUS, 32'h4);
      busWrite(ADDR_CHCTRL_BASE + 4'd2, 32'h0);
      busWrite(ADDR_STATUS, 32'hF);
      busRead("collision_cleared", ADDR_STATUS, 32'd0);

      // Mask and simultaneous expiry of channels 0 and 3
      busWrite(ADDR_CTRL, 32'd0);
      busWrite(ADDR_IRQ_EN, 32'h8);
      busWrite(ADDR_PERIOD_BASE, 32'd0);
      busWrite(ADDR_PERIOD_BASE + 4'd3, 32'd0);
      busWrite(ADDR_CHCTRL_BASE, 32'h1);
      busWrite(ADDR_CHCTRL_BASE + 4'd3, 32'h1);
      checkOutput("mask_irq_idle", 32'(irq), 32'd0);
      busWrite(ADDR_CTRL, 32'd1);
      idleCycles(1);
      busRead("mask_status_both", ADDR_STATUS, 32'h9);
      checkOutput("mask_irq_bit3", 32'(irq), 32'd1);
      busWrite(ADDR_STATUS, 32'h8);
      busRead("mask_status_bit0", ADDR_STATUS, 32'h1);
      checkOutput("mask_irq_masked", 32'(irq), 32'd0);
      busWrite(ADDR_STATUS, 32'hF);
      busWrite(ADDR_IRQ_EN, 32'd0);

      // Global enable freeze and prescaler restart on PRESCALE write
      busWrite(ADDR_PERIOD_BASE, 32'd50);
      busWrite(ADDR_CHCTRL_BASE, 32'h3);
      idleCycles(5);
      busWrite(ADDR_CTRL, 32'd0);
      busRead("freeze_count_start", ADDR_COUNT_BASE, 32'd44);
      idleCycles(100);
      busWrite(ADDR_PERIOD_BASE, 32'd7);
      busRead("freeze_count_end", ADDR_COUNT_BASE, 32'd44);
      busRead("freeze_chctrl", ADDR_CHCTRL_BASE, 32'h3);
      busWrite(ADDR_PRESCALE, 32'd200);
      busWrite(ADDR_CTRL, 32'd1);
      busWrite(ADDR_PRESCALE, 32'd9);
      idleCycles(9);
      busRead("prescale_before_dec", ADDR_COUNT_BASE, 32'd44);
      busRead("prescale_first_dec", ADDR_COUNT_BASE, 32'd43);
      idleCycles(8);
      busRead("prescale_before_dec2", ADDR_COUNT_BASE, 32'd43);
      busRead("prescale_second_dec", ADDR_COUNT_BASE, 32'd42);

      idleCycles(2);
      checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
